// File: rtl/aludec_seq_pkg.sv
// aludec_seq_pkg: shared ALU operation codes, sequencer state encoding and
// the R/I-type funct3 decode helper used by the aludec_seq controller slice.
// No ports; imported by aludec_seq and aludec_mdu_seq.
package aludec_seq_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ADD_OP  = 4'b0000;
    localparam logic [ALU_W-1:0] SUB_OP  = 4'b0001;
    localparam logic [ALU_W-1:0] AND_OP  = 4'b0010;
    localparam logic [ALU_W-1:0] OR_OP   = 4'b0011;
    localparam logic [ALU_W-1:0] XOR_OP  = 4'b0100;
    localparam logic [ALU_W-1:0] SLT_OP  = 4'b0101;
    localparam logic [ALU_W-1:0] SLTU_OP = 4'b0110;
    localparam logic [ALU_W-1:0] SLL_OP  = 4'b0111;
    localparam logic [ALU_W-1:0] SRL_OP  = 4'b1000;
    localparam logic [ALU_W-1:0] SRA_OP  = 4'b1001;
    localparam logic [ALU_W-1:0] NOP_OP  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // funct3 decode for ALUOp==10; SUB needs an R-type opcode, SRA does not.
    function automatic logic [ALU_W-1:0] funct3_op(input logic [2:0] funct3,
                                                   input logic       opb5,
                                                   input logic       funct7b5);
        logic [ALU_W-1:0] op;
        op = ADD_OP;
        case (funct3)
            3'b000:  op = (opb5 && funct7b5) ? SUB_OP : ADD_OP;
            3'b001:  op = SLL_OP;
            3'b010:  op = SLT_OP;
            3'b011:  op = SLTU_OP;
            3'b100:  op = XOR_OP;
            3'b101:  op = funct7b5 ? SRA_OP : SRL_OP;
            3'b110:  op = OR_OP;
            default: op = AND_OP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/aludec_seq_if.sv
// aludec_seq_if: decode-stage bundle between the controller front end and
// aludec_seq.
//   master: drives valid_i, flush_i, opb5, funct3, funct7b5, funct7b0, ALUOp;
//           receives ALUControl, mdu_start, mdu_op, stall, mdu_valid.
//   slave : the decoder side (mirror of master).
interface aludec_seq_if #(
    parameter int unsigned CTRL_W = 4
);
    logic              valid_i;
    logic              flush_i;
    logic              opb5;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              funct7b0;
    logic [1:0]        ALUOp;
    logic [CTRL_W-1:0] ALUControl;
    logic              mdu_start;
    logic [2:0]        mdu_op;
    logic              stall;
    logic              mdu_valid;

    modport master (
        output valid_i, flush_i, opb5, funct3, funct7b5, funct7b0, ALUOp,
        input  ALUControl, mdu_start, mdu_op, stall, mdu_valid
    );

    modport slave (
        input  valid_i, flush_i, opb5, funct3, funct7b5, funct7b0, ALUOp,
        output ALUControl, mdu_start, mdu_op, stall, mdu_valid
    );
endinterface

// File: rtl/aludec_mdu_seq.sv
// aludec_mdu_seq: multi-cycle M-extension sequencer (IDLE/BUSY/DONE).
// Compiled only when ALUDEC_MEXT_EN is defined.
// Ports: clk, reset_n (sync, active-low), mop (M-op present), flush,
//        funct3 -> stall, mdu_start, mdu_op, mdu_valid.
`ifdef ALUDEC_MEXT_EN
module aludec_mdu_seq
    import aludec_seq_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mop,
    input  logic       flush,
    input  logic [2:0] funct3,
    output logic       stall,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       mdu_valid
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             start_q;
    logic [2:0]       op_q;

    // State, counter, latched op and first-BUSY-cycle flag; flush beats everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= 3'b000;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (mop) begin
                            state   <= BUSY;
                            op_q    <= funct3;
                            cnt     <= funct3[2] ? DIV_LOAD : MUL_LOAD;
                            start_q <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (cnt == '0) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    // Held M-op on the inputs is deliberately not relaunched here.
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // IDLE stall is combinational so the front end freezes in the decode cycle.
    assign stall     = reset_n && (((state == IDLE) && mop && !flush) || (state == BUSY));
    assign mdu_start = reset_n && start_q;
    assign mdu_valid = reset_n && (state == DONE) && !flush;
    assign mdu_op    = op_q;

endmodule
`endif

// File: rtl/aludec_seq.sv
// aludec_seq: RV32I ALU decoder with optional M-extension sequencer.
// Ports: clk, reset_n (sync, active-low), bus (aludec_seq_if.slave):
//   inputs  valid_i, flush_i, opb5, funct3, funct7b5, funct7b0, ALUOp
//   outputs ALUControl (combinational), mdu_start, mdu_op, stall, mdu_valid
// Macro ALUDEC_MEXT_EN: when defined, M-ops are detected and sequenced by
// aludec_mdu_seq; when undefined, the MDU outputs are tied 0 and funct7b0
// is ignored. CTRL_W must be at least 4; upper bits are zero.
module aludec_seq
    import aludec_seq_pkg::*;
#(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic         clk,
    input logic         reset_n,
    aludec_seq_if.slave bus
);

    logic             mop_c;
    logic [ALU_W-1:0] op_c;

`ifdef ALUDEC_MEXT_EN
    assign mop_c = bus.valid_i && (bus.ALUOp == 2'b10) && bus.opb5 && bus.funct7b0;

    aludec_mdu_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .mop       (mop_c),
        .flush     (bus.flush_i),
        .funct3    (bus.funct3),
        .stall     (bus.stall),
        .mdu_start (bus.mdu_start),
        .mdu_op    (bus.mdu_op),
        .mdu_valid (bus.mdu_valid)
    );
`else
    localparam int unsigned unused_cycles = MUL_CYCLES + DIV_CYCLES;
    logic unused_inputs;

    assign unused_inputs  = ^{clk, reset_n, bus.valid_i, bus.flush_i, bus.funct7b0};
    assign mop_c          = 1'b0;
    assign bus.stall      = 1'b0;
    assign bus.mdu_start  = 1'b0;
    assign bus.mdu_valid  = 1'b0;
    assign bus.mdu_op     = 3'b000;
`endif

    // Operation decode; an M-op hands the result path to the MDU, so the ALU idles.
    always_comb begin
        op_c = ADD_OP;
        case (bus.ALUOp)
            2'b00:   op_c = ADD_OP;
            2'b01:   op_c = SUB_OP;
            2'b10:   op_c = funct3_op(bus.funct3, bus.opb5, bus.funct7b5);
            default: op_c = NOP_OP;
        endcase
        if (mop_c) begin
            op_c = NOP_OP;
        end
    end

    assign bus.ALUControl = CTRL_W'(op_c);

endmodule
